mlaccel_qspi_resp: RTL and testbench

Accelerator-side QSPI responder: the far end of the ml_clk/ml_csb/ml_io[3:0] link driven by the control SoC.
- Oversamples the host's SCK/CSB in the single system clock domain.
- Decodes a one-byte command.
- Delivers write-burst bytes on a valid/ready stream, and returns status or read-stream bytes on the quad IO lines.
- Reports protocol faults on a sticky error flag, which feeds the ml_err pin.

---
 rtl/mlaccel_qspi_resp.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_mlaccel_qspi_resp.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlaccel_qspi_resp.sv
// mlaccel_qspi_resp: accelerator-side QSPI responder. It oversamples the host
// SCK/CSB/IO in the system clock domain and decodes a one-byte command. Write
// bursts go out on a valid/ready stream. Status or read-stream bytes are
// returned on the quad IO lines. Protocol faults raise a sticky error flag.
module mlaccel_qspi_resp #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DUMMY_CYCLES = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       qspi_clk,
    input  logic       qspi_csb,
    input  logic [3:0] qspi_io_i,
    output logic [3:0] qspi_io_o,
    output logic [3:0] qspi_io_oe,
    output logic       wr_valid,
    input  logic       wr_ready,
    output logic [7:0] wr_data,
    output logic       wr_first,
    input  logic       rd_valid,
    output logic       rd_ready,
    input  logic [7:0] rd_data,
    input  logic [7:0] status,
    output logic       err,
    input  logic       err_clr,
    output logic       busy
);

    localparam int unsigned DCNT_W = (DUMMY_CYCLES > 2) ? $clog2(DUMMY_CYCLES) : 1;
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DUMMY_CYCLES - 1);
    localparam logic [7:0] CMD_WRITE = 8'h21;
    localparam logic [7:0] CMD_STAT  = 8'h05;
    localparam logic [7:0] CMD_READ  = 8'h0B;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WRITE,
        S_STAT,
        S_DUMMY,
        S_READ,
        S_IGNORE
    } state_t;

    state_t state;
    state_t state_next;

    // Synchronizer chains; CSB is stored inverted so the chain resets to "deselected".
    logic [SYNC_STAGES-1:0]      sck_sync;
    logic [SYNC_STAGES-1:0]      sel_sync;
    logic [SYNC_STAGES-1:0][3:0] io_sync;
    logic                        sck_prev;
    logic                        sel_prev;

    logic       sck_s;
    logic       sel_s;
    logic [3:0] io_s;
    logic       sck_rise;
    logic       sck_fall;
    logic       sel_rise;

    // Datapath registers
    logic              in_half;
    logic [3:0]        in_hi;
    logic              out_half;
    logic [DCNT_W-1:0] dcnt;
    logic [7:0]        cap;
    logic              first_pend;

    // Control strobes from the FSM
    logic       in_store;
    logic       in_done;
    logic       w_byte;
    logic       start_write;
    logic       bad_cmd;
    logic       fetch;
    logic       drive;
    logic       dummy_tick;
    logic       wr_accept;
    logic       err_set;
    logic [7:0] in_byte;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign sel_s    = sel_sync[SYNC_STAGES-1];
    assign io_s     = io_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;
    assign sel_rise = sel_s & ~sel_prev;
    assign busy     = sel_s;
    assign in_byte  = {in_hi, io_s};

    // Bring the pad signals into the clk domain and keep one-cycle history for edges.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sck_sync <= '0;
            sel_sync <= '0;
            io_sync  <= '0;
            sck_prev <= 1'b0;
            sel_prev <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], qspi_clk};
            sel_sync <= {sel_sync[SYNC_STAGES-2:0], ~qspi_csb};
            io_sync  <= {io_sync[SYNC_STAGES-2:0], qspi_io_i};
            sck_prev <= sck_s;
            sel_prev <= sel_s;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_next  = state;
        in_store    = 1'b0;
        in_done     = 1'b0;
        w_byte      = 1'b0;
        start_write = 1'b0;
        bad_cmd     = 1'b0;
        fetch       = 1'b0;
        drive       = 1'b0;
        dummy_tick  = 1'b0;
        if (!sel_s) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (sel_rise) state_next = S_CMD;
                end
                S_CMD: begin
                    if (sck_rise) begin
                        if (!in_half) begin
                            in_store = 1'b1;
                        end else begin
                            in_done = 1'b1;
                            case (in_byte)
                                CMD_WRITE: begin
                                    state_next  = S_WRITE;
                                    start_write = 1'b1;
                                end
                                CMD_STAT: begin
                                    state_next = S_STAT;
                                end
                                CMD_READ: begin
                                    state_next = S_DUMMY;
                                    fetch      = 1'b1;
                                end
                                default: begin
                                    state_next = S_IGNORE;
                                    bad_cmd    = 1'b1;
                                end
                            endcase
                        end
                    end
                end
                S_WRITE: begin
                    if (sck_rise) begin
                        if (!in_half) begin
                            in_store = 1'b1;
                        end else begin
                            in_done = 1'b1;
                            w_byte  = 1'b1;
                        end
                    end
                end
                S_STAT: begin
                    drive = sck_fall;
                end
                S_DUMMY: begin
                    if (sck_rise) begin
                        dummy_tick = 1'b1;
                        if (dcnt == DCNT_LAST) state_next = S_READ;
                    end
                end
                S_READ: begin
                    drive = sck_fall;
                    fetch = sck_fall & out_half;
                end
                S_IGNORE: begin
                    state_next = S_IGNORE;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    assign wr_accept = w_byte & (~wr_valid | wr_ready);
    assign err_set   = bad_cmd | (w_byte & ~wr_accept) | (fetch & ~rd_valid);

    // Nibble assembly, dummy count and IO drive; all cleared whenever the host deselects.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            in_half    <= 1'b0;
            in_hi      <= '0;
            out_half   <= 1'b0;
            dcnt       <= '0;
            qspi_io_o  <= '0;
            qspi_io_oe <= '0;
        end else if (!sel_s || state == S_IDLE) begin
            in_half    <= 1'b0;
            out_half   <= 1'b0;
            dcnt       <= '0;
            qspi_io_o  <= '0;
            qspi_io_oe <= '0;
        end else begin
            if (in_store) begin
                in_hi   <= io_s;
                in_half <= 1'b1;
            end
            if (in_done) in_half <= 1'b0;
            if (dummy_tick) dcnt <= dcnt + DCNT_W'(1);
            if (drive) begin
                out_half   <= ~out_half;
                qspi_io_oe <= 4'hF;
                if (!out_half) begin
                    qspi_io_o <= (state == S_STAT) ? status[7:4] : cap[7:4];
                end else begin
                    qspi_io_o <= cap[3:0];
                end
            end
        end
    end

    // Outgoing byte capture: read-stream pops (zero on underflow) or status latch.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cap      <= '0;
            rd_ready <= 1'b0;
        end else begin
            rd_ready <= fetch & rd_valid;
            if (fetch) begin
                cap <= rd_valid ? rd_data : 8'h00;
            end else if (drive && state == S_STAT && !out_half) begin
                cap <= status;
            end
        end
    end

    // Write stream handshake; independent of CSB so a pending byte is never lost.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_valid   <= 1'b0;
            wr_data    <= '0;
            wr_first   <= 1'b0;
            first_pend <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_valid <= 1'b1;
                wr_data  <= in_byte;
                wr_first <= first_pend;
            end else if (wr_valid && wr_ready) begin
                wr_valid <= 1'b0;
            end
            if (start_write) begin
                first_pend <= 1'b1;
            end else if (w_byte) begin
                first_pend <= 1'b0;
            end
        end
    end

    // Sticky protocol error; a clear request beats a same-cycle set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err <= 1'b0;
        end else if (err_clr) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mlaccel_qspi_resp.sv
// Testbench for mlaccel_qspi_resp: a QSPI host model drives transactions and
// results are compared against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mlaccel_qspi_resp;

    localparam int unsigned SYNC  = 2;
    localparam int unsigned DUMMY = 4;
    localparam int          HALF  = 6;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       qspi_clk = 1'b0;
    logic       qspi_csb = 1'b1;
    logic [3:0] qspi_io_i = 4'h0;
    logic [3:0] qspi_io_o;
    logic [3:0] qspi_io_oe;
    logic       wr_valid;
    logic       wr_ready = 1'b0;
    logic [7:0] wr_data;
    logic       wr_first;
    logic       rd_valid = 1'b0;
    logic       rd_ready;
    logic [7:0] rd_data = 8'h00;
    logic [7:0] status = 8'h00;
    logic       err;
    logic       err_clr = 1'b0;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    // Consumer-side record of delivered write bytes
    logic [7:0] got_d [0:255];
    logic       got_f [0:255];
    int         got_n = 0;

    // Read-stream source
    logic [7:0] rd_arr [0:255];
    int         rd_idx  = 0;
    int         rd_lim  = 0;
    int         rd_pops = 0;

    // Host-side transfer buffers
    logic [7:0] tx_d [0:7];
    int         tx_len = 0;
    logic [3:0] rx_nib [0:63];
    logic [3:0] rx_oe  [0:63];
    logic [3:0] cmd_oe [0:1];

    always #5 clk = ~clk;

    mlaccel_qspi_resp #(
        .SYNC_STAGES  (SYNC),
        .DUMMY_CYCLES (DUMMY)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .qspi_clk   (qspi_clk),
        .qspi_csb   (qspi_csb),
        .qspi_io_i  (qspi_io_i),
        .qspi_io_o  (qspi_io_o),
        .qspi_io_oe (qspi_io_oe),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .wr_first   (wr_first),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .status     (status),
        .err        (err),
        .err_clr    (err_clr),
        .busy       (busy)
    );

    // Write consumer: log every completed handshake.
    always @(posedge clk) begin
        if (wr_valid && wr_ready) begin
            got_d[got_n] = wr_data;
            got_f[got_n] = wr_first;
            got_n = got_n + 1;
        end
    end

    // Read source: each rd_ready pulse pops one byte.
    always @(negedge clk) begin
        if (rd_ready) begin
            rd_pops = rd_pops + 1;
            rd_idx  = rd_idx + 1;
        end
        rd_valid = (rd_idx < rd_lim);
        rd_data  = rd_valid ? rd_arr[rd_idx] : 8'hEE;
    end

    task automatic sck_cycle(input logic [3:0] nib, output logic [3:0] o, output logic [3:0] oe);
        qspi_io_i = nib;
        repeat (HALF) @(negedge clk);
        o  = qspi_io_o;
        oe = qspi_io_oe;
        qspi_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        qspi_clk = 1'b0;
    endtask

    task automatic csb_on();
        qspi_csb = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic csb_off();
        repeat (HALF) @(negedge clk);
        qspi_csb = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic clear_err();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    // Complete transaction: command byte then n_cyc SCK cycles carrying tx_d.
    task automatic run_xfer(input logic [7:0] cmd, input int n_cyc);
        logic [3:0] o;
        logic [3:0] oe;
        logic [3:0] nib;
        csb_on();
        sck_cycle(cmd[7:4], o, oe);
        cmd_oe[0] = oe;
        sck_cycle(cmd[3:0], o, oe);
        cmd_oe[1] = oe;
        for (int k = 0; k < n_cyc; k++) begin
            if (k < 2 * tx_len) nib = (k % 2 == 0) ? tx_d[k/2][7:4] : tx_d[k/2][3:0];
            else nib = 4'h0;
            sck_cycle(nib, o, oe);
            rx_nib[k] = o;
            rx_oe[k]  = oe;
        end
        csb_off();
    endtask

    // Reference: nibble k of a read returns stream bytes high-first, then zeros.
    function automatic logic [3:0] ref_read_nib(input int k, input int base, input int len);
        logic [7:0] b;
        b = (k / 2 < len) ? rd_arr[base + k / 2] : 8'h00;
        return (k % 2 == 0) ? b[7:4] : b[3:0];
    endfunction

    task automatic test_reset();
        logic [3:0] o_vals [0:1];
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (qspi_io_o !== 4'h0) $display("FAIL reset_io_o got %h exp 0", qspi_io_o); else n_pass++;
        n_checks++; if (qspi_io_oe !== 4'h0) $display("FAIL reset_io_oe got %h exp 0", qspi_io_oe); else n_pass++;
        n_checks++; if (wr_valid !== 1'b0) $display("FAIL reset_wr_valid got %b exp 0", wr_valid); else n_pass++;
        n_checks++; if (wr_data !== 8'h00) $display("FAIL reset_wr_data got %h exp 00", wr_data); else n_pass++;
        n_checks++; if (wr_first !== 1'b0) $display("FAIL reset_wr_first got %b exp 0", wr_first); else n_pass++;
        n_checks++; if (rd_ready !== 1'b0) $display("FAIL reset_rd_ready got %b exp 0", rd_ready); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL reset_err got %b exp 0", err); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        o_vals[0] = qspi_io_oe;
        n_checks++; if (o_vals[0] !== 4'h0) $display("FAIL post_reset_oe got %h exp 0", o_vals[0]); else n_pass++;
    endtask

    task automatic test_write_basic();
        int base;
        base = got_n;
        wr_ready = 1'b1;
        tx_d[0] = 8'hA5; tx_d[1] = 8'h3C; tx_len = 2;
        run_xfer(8'h21, 4);
        n_checks++; if (got_n - base !== 2) $display("FAIL wr_basic_count got %0d exp 2", got_n - base); else n_pass++;
        n_checks++; if (got_d[base] !== 8'hA5 || got_f[base] !== 1'b1)
            $display("FAIL wr_basic_b0 got %h/%b exp a5/1", got_d[base], got_f[base]); else n_pass++;
        n_checks++; if (got_d[base+1] !== 8'h3C || got_f[base+1] !== 1'b0)
            $display("FAIL wr_basic_b1 got %h/%b exp 3c/0", got_d[base+1], got_f[base+1]); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL wr_basic_err got %b exp 0", err); else n_pass++;
    endtask

    task automatic test_write_overflow();
        logic [3:0] o;
        logic [3:0] oe;
        logic [7:0] bytes [0:2];
        int base;
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
        wr_ready = 1'b0;
        base = got_n;
        csb_on();
        sck_cycle(4'h2, o, oe);
        sck_cycle(4'h1, o, oe);
        for (int i = 0; i < 3; i++) begin
            sck_cycle(bytes[i][7:4], o, oe);
            sck_cycle(bytes[i][3:0], o, oe);
            repeat (2) @(negedge clk);
            n_checks++; if (wr_valid !== 1'b1 || wr_data !== 8'h11 || wr_first !== 1'b1)
                $display("FAIL ovf_hold_%0d got v=%b d=%h f=%b exp 1/11/1", i, wr_valid, wr_data, wr_first); else n_pass++;
            n_checks++; if (err !== (i >= 1)) $display("FAIL ovf_err_%0d got %b exp %b", i, err, (i >= 1)); else n_pass++;
        end
        csb_off();
        n_checks++; if (wr_valid !== 1'b1 || wr_data !== 8'h11)
            $display("FAIL ovf_after_csb got v=%b d=%h exp 1/11", wr_valid, wr_data); else n_pass++;
        clear_err();
        n_checks++; if (err !== 1'b0) $display("FAIL ovf_err_clr got %b exp 0", err); else n_pass++;
        wr_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (got_n - base !== 1 || got_d[base] !== 8'h11)
            $display("FAIL ovf_drain got n=%0d d=%h exp 1/11", got_n - base, got_d[base]); else n_pass++;
        n_checks++; if (wr_valid !== 1'b0) $display("FAIL ovf_drained_valid got %b exp 0", wr_valid); else n_pass++;
    endtask

    task automatic check_status(input logic [7:0] st, input int n, input string tag);
        int bad;
        bad = 0;
        status = st;
        tx_len = 0;
        run_xfer(8'h05, n);
        n_checks++; if (cmd_oe[0] !== 4'h0 || cmd_oe[1] !== 4'h0)
            $display("FAIL %s_cmd_oe got %h %h exp 0 0", tag, cmd_oe[0], cmd_oe[1]); else n_pass++;
        for (int k = 0; k < n; k++) begin
            n_checks++;
            if (rx_nib[k] !== ((k % 2 == 0) ? st[7:4] : st[3:0]) || rx_oe[k] !== 4'hF) begin
                $display("FAIL %s_nib%0d got %h oe %h exp %h oe f", tag, k, rx_nib[k], rx_oe[k],
                         (k % 2 == 0) ? st[7:4] : st[3:0]);
                bad++;
            end else n_pass++;
        end
        n_checks++; if (err !== 1'b0) $display("FAIL %s_err got %b exp 0", tag, err); else n_pass++;
    endtask

    task automatic check_read(input int len, input int nd, input string tag);
        int base;
        int pbase;
        int fetches;
        int exp_pops;
        base  = rd_idx;
        pbase = rd_pops;
        for (int i = 0; i < len; i++) rd_arr[base + i] = 8'($urandom);
        if (tag == "read") begin
            rd_arr[base] = 8'h01;
            rd_arr[base + 1] = 8'h02;
        end
        rd_lim = base + len;
        tx_len = 0;
        repeat (2) @(negedge clk);
        run_xfer(8'h0B, DUMMY + nd);
        fetches  = 1 + (nd + 1) / 2;
        exp_pops = (fetches < len) ? fetches : len;
        for (int k = 0; k < int'(DUMMY); k++) begin
            n_checks++; if (rx_oe[k] !== 4'h0) $display("FAIL %s_dummy_oe%0d got %h exp 0", tag, k, rx_oe[k]); else n_pass++;
        end
        for (int k = 0; k < nd; k++) begin
            n_checks++;
            if (rx_nib[DUMMY + k] !== ref_read_nib(k, base, len) || rx_oe[DUMMY + k] !== 4'hF)
                $display("FAIL %s_nib%0d got %h oe %h exp %h oe f", tag, k, rx_nib[DUMMY + k],
                         rx_oe[DUMMY + k], ref_read_nib(k, base, len));
            else n_pass++;
        end
        n_checks++; if (rd_pops - pbase !== exp_pops)
            $display("FAIL %s_pops got %0d exp %0d", tag, rd_pops - pbase, exp_pops); else n_pass++;
        n_checks++; if (err !== (fetches > len))
            $display("FAIL %s_err got %b exp %b", tag, err, (fetches > len)); else n_pass++;
        rd_lim = rd_idx;
        clear_err();
    endtask

    task automatic test_status();
        check_status(8'h5A, 14, "stat");
    endtask

    task automatic test_read();
        check_read(2, 6, "read");
    endtask

    task automatic test_ignore();
        tx_len = 0;
        run_xfer(8'h77, 4);
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (rx_oe[k] !== 4'h0) $display("FAIL ign_oe%0d got %h exp 0", k, rx_oe[k]); else n_pass++;
        end
        n_checks++; if (err !== 1'b1) $display("FAIL ign_err got %b exp 1", err); else n_pass++;
        clear_err();
        check_status(8'hC3, 4, "ign_next");
    endtask

    task automatic test_csb_abort();
        int base;
        base = got_n;
        wr_ready = 1'b1;
        tx_d[0] = 8'hC3; tx_d[1] = 8'h96; tx_len = 2;
        run_xfer(8'h21, 3);
        n_checks++; if (got_n - base !== 1 || got_d[base] !== 8'hC3 || got_f[base] !== 1'b1)
            $display("FAIL abort_wr got n=%0d d=%h f=%b exp 1/c3/1", got_n - base, got_d[base], got_f[base]); else n_pass++;
        n_checks++; if (qspi_io_oe !== 4'h0 || busy !== 1'b0)
            $display("FAIL abort_idle got oe=%h busy=%b exp 0/0", qspi_io_oe, busy); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL abort_err got %b exp 0", err); else n_pass++;
        check_status(8'h69, 4, "abort_next");
    endtask

    task automatic test_random();
        int kind;
        int nb;
        int extra;
        int base;
        for (int it = 0; it < 9; it++) begin
            kind = int'($urandom_range(0, 2));
            if (kind == 0) begin
                nb = int'($urandom_range(1, 4));
                extra = int'($urandom_range(0, 1));
                for (int i = 0; i < nb; i++) tx_d[i] = 8'($urandom);
                tx_len = nb;
                wr_ready = 1'b1;
                base = got_n;
                run_xfer(8'h21, 2 * nb + extra);
                n_checks++; if (got_n - base !== nb) $display("FAIL rnd_wr_count got %0d exp %0d", got_n - base, nb); else n_pass++;
                for (int i = 0; i < nb; i++) begin
                    n_checks++;
                    if (got_d[base + i] !== tx_d[i] || got_f[base + i] !== (i == 0))
                        $display("FAIL rnd_wr_b%0d got %h/%b exp %h/%b", i, got_d[base + i], got_f[base + i], tx_d[i], (i == 0));
                    else n_pass++;
                end
                n_checks++; if (err !== 1'b0) $display("FAIL rnd_wr_err got %b exp 0", err); else n_pass++;
            end else if (kind == 1) begin
                check_status(8'($urandom), int'($urandom_range(2, 8)), "rnd_stat");
            end else begin
                check_read(int'($urandom_range(0, 4)), int'($urandom_range(2, 8)), "rnd_read");
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_write_overflow();
        test_status();
        test_read();
        test_ignore();
        test_csb_abort();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
